// File: rtl/fixed_arith_pkg.sv
// Shared types and constant helpers for the fixed-point add/subtract scheduler.
package fixed_arith_pkg;

    // Opcode carried with every request: 0 adds, 1 subtracts b from a.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } fixed_op_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idw_of(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // Largest representable signed value for a given width (0x7F.. pattern).
    function automatic longint sat_max(input int bits);
        return (longint'(1) <<< (bits - 1)) - longint'(1);
    endfunction

    // Smallest representable signed value for a given width (0x80.. pattern).
    function automatic longint sat_min(input int bits);
        return -(longint'(1) <<< (bits - 1));
    endfunction

endpackage

// File: rtl/fixed_addsub_core.sv
// Registered signed add/subtract with tag pass-through, overflow flag and
// optional saturation. The output register is the second pipeline stage.
module fixed_addsub_core
    import fixed_arith_pkg::*;
#(
    parameter int    BITS      = 8,
    parameter string PRECISION = "FIXED_4_4",
    parameter int    SATURATE  = 0,
    parameter int    IDW       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [IDW-1:0]         i_in_id,
    input  fixed_op_t              i_in_op,
    input  logic signed [BITS-1:0] i_in_a,
    input  logic signed [BITS-1:0] i_in_b,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [IDW-1:0]         o_out_id,
    output logic signed [BITS-1:0] o_out_c,
    output logic                   o_out_ovf
);

    localparam logic signed [BITS-1:0] C_MAX = BITS'(sat_max(BITS));
    localparam logic signed [BITS-1:0] C_MIN = BITS'(sat_min(BITS));

    // The format label only documents how callers interpret the bits.
    generate
        if (PRECISION == "") begin : g_unlabelled_format
        end
    endgenerate

    // Reduce a BITS+1 wide result to BITS: clamp when saturating, else wrap.
    function automatic logic signed [BITS-1:0] f_saturate(input logic signed [BITS:0] s);
        if ((SATURATE != 0) && (s[BITS] ^ s[BITS-1])) begin
            return s[BITS] ? C_MIN : C_MAX;
        end
        return s[BITS-1:0];
    endfunction

    logic                   w_in_ready;
    logic signed [BITS:0]   w_sum;
    logic                   w_ovf;
    logic signed [BITS-1:0] w_c;

    logic                   r_vld_p2;
    logic [IDW-1:0]         r_id_p2;
    logic signed [BITS-1:0] r_c_p2;
    logic                   r_ovf_p2;

    // The register can take a new op when empty or when its result leaves now.
    assign w_in_ready = !r_vld_p2 || i_out_ready;

    // One extra bit of headroom makes overflow a simple sign-bit disagreement.
    always_comb begin
        w_sum = '0;
        if (i_in_op == OP_SUB) begin
            w_sum = {i_in_a[BITS-1], i_in_a} - {i_in_b[BITS-1], i_in_b};
        end else begin
            w_sum = {i_in_a[BITS-1], i_in_a} + {i_in_b[BITS-1], i_in_b};
        end
        w_ovf = w_sum[BITS] ^ w_sum[BITS-1];
        w_c   = f_saturate(w_sum);
    end

    // ---- stage 2: result register; held bit-stable while backpressured ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2 <= 1'b0;
            r_id_p2  <= '0;
            r_c_p2   <= '0;
            r_ovf_p2 <= 1'b0;
        end else if (w_in_ready) begin
            r_vld_p2 <= i_in_valid;
            if (i_in_valid) begin
                r_id_p2  <= i_in_id;
                r_c_p2   <= w_c;
                r_ovf_p2 <= w_ovf;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_vld_p2;
    assign o_out_id    = r_id_p2;
    assign o_out_c     = r_c_p2;
    assign o_out_ovf   = r_ovf_p2;

endmodule

// File: rtl/fixed_addsub_scheduler.sv
// Round-robin front end sharing one registered add/subtract core among
// N_REQ requesters; results come back tagged with the requester index.
module fixed_addsub_scheduler
    import fixed_arith_pkg::*;
#(
    parameter int    BITS      = 8,
    parameter string PRECISION = "FIXED_4_4",
    parameter int    N_REQ     = 4,
    parameter int    SATURATE  = 0,
    localparam int   IDW       = idw_of(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_op,
    input  logic [N_REQ*BITS-1:0]   req_a,
    input  logic [N_REQ*BITS-1:0]   req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [IDW-1:0]          res_id,
    output logic signed [BITS-1:0]  res_c,
    output logic                    res_ovf
);

    logic                   w_gnt_found;
    logic [IDW-1:0]         w_gnt_idx;
    logic                   w_core_ready;
    logic                   w_s1_adv;
    logic                   w_accept;

    logic [IDW-1:0]         r_last_grant;
    logic                   r_vld_p1;
    logic [IDW-1:0]         r_id_p1;
    fixed_op_t              r_op_p1;
    logic signed [BITS-1:0] r_a_p1;
    logic signed [BITS-1:0] r_b_p1;

    // Search for the first valid requester starting one past the last grant.
    always_comb begin
        logic [IDW:0] v_sum;
        v_sum       = '0;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            v_sum = {1'b0, r_last_grant} + (IDW+1)'(k);
            if (v_sum >= (IDW+1)'(N_REQ)) begin
                v_sum = v_sum - (IDW+1)'(N_REQ);
            end
            if (!w_gnt_found && req_valid[v_sum[IDW-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = v_sum[IDW-1:0];
            end
        end
    end

    // Stage 1 moves when empty or when the core takes its op this cycle;
    // ready is forced low while reset is asserted.
    always_comb begin
        w_s1_adv  = !r_vld_p1 || w_core_ready;
        w_accept  = rst_n && w_gnt_found && w_s1_adv;
        req_ready = '0;
        if (w_accept) begin
            req_ready = N_REQ'(1) << w_gnt_idx;
        end
    end

    // Arbitration pointer and stage-1 occupancy; the pointer moves only on accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IDW'(N_REQ - 1);
            r_vld_p1     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_gnt_idx;
            end
            if (w_s1_adv) begin
                r_vld_p1 <= w_accept;
            end
        end
    end

    // ---- stage 1: issue register, loaded from the granted requester ----
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_id_p1 <= w_gnt_idx;
            r_op_p1 <= fixed_op_t'(req_op[w_gnt_idx]);
            r_a_p1  <= req_a[w_gnt_idx*BITS +: BITS];
            r_b_p1  <= req_b[w_gnt_idx*BITS +: BITS];
        end
    end

    fixed_addsub_core #(
        .BITS      (BITS),
        .PRECISION (PRECISION),
        .SATURATE  (SATURATE),
        .IDW       (IDW)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (r_vld_p1),
        .o_in_ready  (w_core_ready),
        .i_in_id     (r_id_p1),
        .i_in_op     (r_op_p1),
        .i_in_a      (r_a_p1),
        .i_in_b      (r_b_p1),
        .o_out_valid (res_valid),
        .i_out_ready (res_ready),
        .o_out_id    (res_id),
        .o_out_c     (res_c),
        .o_out_ovf   (res_ovf)
    );

endmodule

// File: tb/tb_fixed_addsub_scheduler.sv
// Self-checking bench: a wrapping and a saturating instance share one
// stimulus stream and are checked against a queue-based reference model.
module tb_fixed_addsub_scheduler;

    localparam int NR = 4;
    localparam int B  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_op;
    logic [NR*B-1:0] req_a;
    logic [NR*B-1:0] req_b;
    logic            res_ready;

    logic [NR-1:0]   rdy_w, rdy_s;
    logic            vld_w, vld_s, ovf_w, ovf_s;
    logic [1:0]      id_w, id_s;
    logic [B-1:0]    c_w, c_s;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         id;
        logic [7:0] cw;
        logic [7:0] cs;
        logic       ovf;
        int         acc;
    } exp_t;

    exp_t       q[$];
    int         m_last;
    int         m_edge;
    int         m_g;
    bit         m_found, m_can, exp_vis, drop_on_accept;
    logic [3:0] exp_ready;
    logic [1:0] exp_id;
    logic [7:0] exp_cw, exp_cs;
    logic       exp_ovf;

    always #5 clk = ~clk;

    fixed_addsub_scheduler #(.BITS(B), .N_REQ(NR), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_w),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .res_valid(vld_w),
        .res_ready(res_ready), .res_id(id_w), .res_c(c_w), .res_ovf(ovf_w)
    );

    fixed_addsub_scheduler #(.BITS(B), .N_REQ(NR), .SATURATE(1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_s),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .res_valid(vld_s),
        .res_ready(res_ready), .res_id(id_s), .res_c(c_s), .res_ovf(ovf_s)
    );

    // Reference arithmetic on plain integers.
    function automatic void ref_addsub(input logic op, input logic [7:0] a, input logic [7:0] b,
                                       output logic [7:0] cw, output logic [7:0] cs, output logic ovf);
        int ia, ib, r;
        ia  = int'($signed(a));
        ib  = int'($signed(b));
        r   = op ? (ia - ib) : (ia + ib);
        ovf = (r > 127) || (r < -128);
        cw  = 8'(r);
        cs  = !ovf ? 8'(r) : ((r > 0) ? 8'h7F : 8'h80);
    endfunction

    // Expectations for the current cycle, taken at the falling edge.
    task automatic sample();
        @(negedge clk);
        m_found = 1'b0;
        m_g     = 0;
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (m_last + k) % NR;
            if (!m_found && req_valid[idx]) begin
                m_found = 1'b1;
                m_g     = idx;
            end
        end
        m_can     = (q.size() < 2) || res_ready;
        exp_ready = (m_found && m_can) ? 4'(1 << m_g) : 4'b0000;
        exp_vis   = (q.size() > 0) && (q[0].acc + 1 < m_edge);
        exp_id    = exp_vis ? 2'(q[0].id) : 2'd0;
        exp_cw    = exp_vis ? q[0].cw : 8'h00;
        exp_cs    = exp_vis ? q[0].cs : 8'h00;
        exp_ovf   = exp_vis ? q[0].ovf : 1'b0;
    endtask

    // Apply this cycle's transfers to the model, then cross the rising edge.
    task automatic advance();
        exp_t e;
        bit   acc;
        int   g;
        acc = m_found && m_can;
        g   = m_g;
        if (exp_vis && res_ready) void'(q.pop_front());
        if (acc) begin
            e.id  = g;
            e.acc = m_edge;
            ref_addsub(req_op[g], req_a[g*B +: B], req_b[g*B +: B], e.cw, e.cs, e.ovf);
            q.push_back(e);
            m_last = g;
        end
        m_edge++;
        @(posedge clk);
        #1;
        if (acc) begin
            if (drop_on_accept) begin
                req_valid[g] = 1'b0;
            end else begin
                req_op[g]        = 1'($urandom);
                req_a[g*B +: B]  = 8'($urandom);
                req_b[g*B +: B]  = 8'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
        #1 rst_n = 1'b0;
        req_valid = 4'hF;
        #12;
        n_tests++;
        if ({rdy_w, rdy_s} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b/%b want 0000", rdy_w, rdy_s);
        end
        n_tests++;
        if ({vld_w, id_w, c_w, ovf_w, vld_s, id_s, c_s, ovf_s} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b id=%0d c=%h o=%b / v=%b id=%0d c=%h o=%b want all 0",
                     vld_w, id_w, c_w, ovf_w, vld_s, id_s, c_s, ovf_s);
        end
        req_valid = '0;
        q.delete();
        m_last = NR - 1;
        m_edge = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        drop_on_accept = 1'b1;
        res_ready = 1'b1;
        req_op[0] = 1'b0; req_a[7:0] = 8'h10; req_b[7:0] = 8'h20; req_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            sample();
            n_tests++;
            if (rdy_w !== exp_ready || rdy_s !== exp_ready) begin
                n_fail++;
                $display("FAIL single_ready[%0d]: got %b/%b want %b", i, rdy_w, rdy_s, exp_ready);
            end
            n_tests++;
            if (exp_vis ? ({vld_w, id_w, c_w, ovf_w} !== {1'b1, exp_id, exp_cw, exp_ovf} ||
                           {vld_s, id_s, c_s, ovf_s} !== {1'b1, exp_id, exp_cs, exp_ovf})
                        : (vld_w !== 1'b0 || vld_s !== 1'b0)) begin
                n_fail++;
                $display("FAIL single_result[%0d]: got %b/%0d/%h/%b want vis=%b id=%0d c=%h o=%b",
                         i, vld_w, id_w, c_w, ovf_w, exp_vis, exp_id, exp_cw, exp_ovf);
            end
            if (i == 2) begin
                n_tests++;
                if ({vld_w, id_w, c_w, ovf_w} !== {1'b1, 2'd0, 8'h30, 1'b0}) begin
                    n_fail++;
                    $display("FAIL single_latency: got v=%b id=%0d c=%h o=%b want 1/0/30/0", vld_w, id_w, c_w, ovf_w);
                end
            end
            advance();
        end
    endtask

    task automatic test_overflow();
        drop_on_accept = 1'b1;
        res_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                req_op[1] = 1'b1; req_a[15:8] = 8'h80; req_b[15:8] = 8'h01; req_valid = 4'b0010;
            end else begin
                req_op[2] = 1'b0; req_a[23:16] = 8'h7F; req_b[23:16] = 8'h01; req_valid = 4'b0100;
            end
            for (int i = 0; i < 4; i++) begin
                sample();
                n_tests++;
                if (rdy_w !== exp_ready || rdy_s !== exp_ready) begin
                    n_fail++;
                    $display("FAIL ovf_ready[%0d.%0d]: got %b/%b want %b", t, i, rdy_w, rdy_s, exp_ready);
                end
                if (i == 2) begin
                    n_tests++;
                    if ({vld_w, c_w, ovf_w, vld_s, c_s, ovf_s} !==
                        ((t == 0) ? {1'b1, 8'h7F, 1'b1, 1'b1, 8'h80, 1'b1}
                                  : {1'b1, 8'h80, 1'b1, 1'b1, 8'h7F, 1'b1})) begin
                        n_fail++;
                        $display("FAIL ovf_result[%0d]: got wrap %b/%h/%b sat %b/%h/%b", t,
                                 vld_w, c_w, ovf_w, vld_s, c_s, ovf_s);
                    end
                    n_tests++;
                    if (id_w !== 2'(t + 1) || id_s !== 2'(t + 1)) begin
                        n_fail++;
                        $display("FAIL ovf_id[%0d]: got %0d/%0d want %0d", t, id_w, id_s, t + 1);
                    end
                end
                advance();
            end
        end
    endtask

    task automatic test_contention();
        int n_res;
        n_res = 0;
        drop_on_accept = 1'b0;
        res_ready = 1'b1;
        for (int r = 0; r < NR; r++) begin
            req_op[r] = 1'($urandom); req_a[r*B +: B] = 8'($urandom); req_b[r*B +: B] = 8'($urandom);
        end
        req_valid = 4'hF;
        for (int i = 0; i < 15; i++) begin
            if (i == 12) req_valid = '0;
            sample();
            if (i < 12) begin
                // The previous scenario left requester 2 as the last grant.
                n_tests++;
                if (rdy_w !== 4'(1 << ((3 + i) % 4)) || rdy_s !== rdy_w) begin
                    n_fail++;
                    $display("FAIL contention_order[%0d]: got %b/%b want %b", i, rdy_w, rdy_s, 4'(1 << ((3 + i) % 4)));
                end
            end
            n_tests++;
            if (exp_vis ? ({vld_w, id_w, c_w, ovf_w} !== {1'b1, exp_id, exp_cw, exp_ovf} ||
                           {vld_s, id_s, c_s, ovf_s} !== {1'b1, exp_id, exp_cs, exp_ovf})
                        : (vld_w !== 1'b0 || vld_s !== 1'b0)) begin
                n_fail++;
                $display("FAIL contention_result[%0d]: got %b/%0d/%h/%b want vis=%b id=%0d c=%h o=%b",
                         i, vld_w, id_w, c_w, ovf_w, exp_vis, exp_id, exp_cw, exp_ovf);
            end
            if (vld_w) n_res++;
            advance();
        end
        n_tests++;
        if (n_res !== 12) begin
            n_fail++;
            $display("FAIL contention_count: got %0d results want 12", n_res);
        end
    endtask

    task automatic test_sparse();
        drop_on_accept = 1'b0;
        res_ready = 1'b1;
        req_valid = 4'b0101;
        for (int i = 0; i < 11; i++) begin
            if (i == 8) req_valid = '0;
            sample();
            if (i < 8) begin
                n_tests++;
                if (rdy_w !== ((i % 2 == 0) ? 4'b0001 : 4'b0100) || rdy_s !== rdy_w) begin
                    n_fail++;
                    $display("FAIL sparse_order[%0d]: got %b/%b want %b", i, rdy_w, rdy_s,
                             (i % 2 == 0) ? 4'b0001 : 4'b0100);
                end
            end
            n_tests++;
            if (exp_vis ? ({vld_w, id_w, c_w, ovf_w} !== {1'b1, exp_id, exp_cw, exp_ovf} ||
                           {vld_s, id_s, c_s, ovf_s} !== {1'b1, exp_id, exp_cs, exp_ovf})
                        : (vld_w !== 1'b0 || vld_s !== 1'b0)) begin
                n_fail++;
                $display("FAIL sparse_result[%0d]: got %b/%0d/%h/%b want vis=%b id=%0d c=%h o=%b",
                         i, vld_w, id_w, c_w, ovf_w, exp_vis, exp_id, exp_cw, exp_ovf);
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        int         n_acc, n_res;
        logic [7:0] held;
        n_acc = 0; n_res = 0; held = '0;
        drop_on_accept = 1'b0;
        res_ready = 1'b0;
        req_valid = 4'b1000;
        for (int i = 0; i < 9; i++) begin
            if (i == 5) begin
                res_ready = 1'b1;
                req_valid = '0;
            end
            sample();
            if (i < 5 && rdy_w[3]) n_acc++;
            if (i >= 5 && vld_w) n_res++;
            if (i == 2) held = c_w;
            if (i == 3 || i == 4) begin
                n_tests++;
                if (vld_w !== 1'b1 || c_w !== held || rdy_w !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL bp_hold[%0d]: got v=%b c=%h rdy=%b want 1/%h/0000", i, vld_w, c_w, rdy_w, held);
                end
            end
            n_tests++;
            if (exp_vis ? ({vld_w, id_w, c_w, ovf_w} !== {1'b1, exp_id, exp_cw, exp_ovf} ||
                           {vld_s, id_s, c_s, ovf_s} !== {1'b1, exp_id, exp_cs, exp_ovf})
                        : (vld_w !== 1'b0 || vld_s !== 1'b0)) begin
                n_fail++;
                $display("FAIL bp_result[%0d]: got %b/%0d/%h/%b want vis=%b id=%0d c=%h o=%b",
                         i, vld_w, id_w, c_w, ovf_w, exp_vis, exp_id, exp_cw, exp_ovf);
            end
            advance();
        end
        n_tests++;
        if (n_acc !== 2 || n_res !== 2) begin
            n_fail++;
            $display("FAIL bp_counts: got %0d accepts %0d results want 2 and 2", n_acc, n_res);
        end
    endtask

    task automatic test_reset_mid();
        drop_on_accept = 1'b0;
        res_ready = 1'b0;
        req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_tests++;
            if (rdy_w !== exp_ready || rdy_s !== exp_ready) begin
                n_fail++;
                $display("FAIL rstmid_fill[%0d]: got %b/%b want %b", i, rdy_w, rdy_s, exp_ready);
            end
            advance();
        end
        n_tests++;
        if (vld_w !== 1'b1 || vld_s !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got res_valid %b/%b want 1", vld_w, vld_s);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({vld_w, vld_s, rdy_w, rdy_s, c_w, ovf_w, id_w} !== 21'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: got v=%b/%b rdy=%b/%b c=%h o=%b id=%0d want all 0",
                     vld_w, vld_s, rdy_w, rdy_s, c_w, ovf_w, id_w);
        end
        q.delete();
        m_last = NR - 1;
        req_valid = 4'hF;
        res_ready = 1'b1;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (i == 0) begin
                n_tests++;
                if (rdy_w !== 4'b0001 || rdy_s !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL rstmid_first_grant: got %b/%b want 0001", rdy_w, rdy_s);
                end
            end
            n_tests++;
            if (exp_vis ? ({vld_w, id_w, c_w, ovf_w} !== {1'b1, exp_id, exp_cw, exp_ovf} ||
                           {vld_s, id_s, c_s, ovf_s} !== {1'b1, exp_id, exp_cs, exp_ovf})
                        : (vld_w !== 1'b0 || vld_s !== 1'b0)) begin
                n_fail++;
                $display("FAIL rstmid_result[%0d]: got %b/%0d/%h/%b want vis=%b id=%0d c=%h o=%b",
                         i, vld_w, id_w, c_w, ovf_w, exp_vis, exp_id, exp_cw, exp_ovf);
            end
            advance();
        end
    endtask

    task automatic test_random();
        drop_on_accept = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 306; i++) begin
            if (i < 300) begin
                res_ready = ($urandom_range(0, 3) != 0);
                for (int r = 0; r < NR; r++) begin
                    if (!req_valid[r] && $urandom_range(0, 1) == 1) begin
                        req_valid[r]     = 1'b1;
                        req_op[r]        = 1'($urandom);
                        req_a[r*B +: B]  = 8'($urandom);
                        req_b[r*B +: B]  = 8'($urandom);
                    end
                end
            end else begin
                res_ready = 1'b1;
                req_valid = '0;
            end
            sample();
            n_tests++;
            if (rdy_w !== exp_ready || rdy_s !== exp_ready) begin
                n_fail++;
                $display("FAIL random_ready[%0d]: got %b/%b want %b", i, rdy_w, rdy_s, exp_ready);
            end
            n_tests++;
            if (exp_vis ? ({vld_w, id_w, c_w, ovf_w} !== {1'b1, exp_id, exp_cw, exp_ovf} ||
                           {vld_s, id_s, c_s, ovf_s} !== {1'b1, exp_id, exp_cs, exp_ovf})
                        : (vld_w !== 1'b0 || vld_s !== 1'b0)) begin
                n_fail++;
                $display("FAIL random_result[%0d]: got %b/%0d/%h/%b sat %h want vis=%b id=%0d c=%h/%h o=%b",
                         i, vld_w, id_w, c_w, ovf_w, c_s, exp_vis, exp_id, exp_cw, exp_cs, exp_ovf);
            end
            advance();
        end
    endtask

    initial begin
        drop_on_accept = 1'b1;
        test_reset();
        test_single();
        test_overflow();
        test_contention();
        test_sparse();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
